// File: rtl/boost_plant_emulator.sv
// Boost-converter plant model for closing the FCS-MPC loop on-chip.
// Integrates inductor current and capacitor voltage in Q8.8 once every
// SAMPLE_DIV clocks, driven by the synchronised controller gate.
module boost_plant_emulator #(
   parameter int          SAMPLE_DIV = 100,
   parameter int          L_SHIFT    = 4,
   parameter int          C_SHIFT    = 5,
   parameter int          R_SHIFT    = 3,
   parameter logic [7:0]  VG_DEFAULT = 8'd12
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        enable_i,
   input  logic        gate_i,
   input  logic        vg_load_i,
   input  logic [7:0]  vg_set_i,
   output logic [7:0]  il_o,
   output logic [7:0]  vc_o,
   output logic [7:0]  vg_o,
   output logic        valid_o,
   output logic        sat_o
);

   localparam int            CW       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_DIV - 1);

   logic          gate_m;
   logic          gate_s;
   logic [CW-1:0] cnt;
   logic          tick;
   logic [15:0]   il_q;
   logic [15:0]   vc_q;

   logic signed [17:0] il_w, vc_w, vg_w, i_load;
   logic signed [17:0] v_l, i_c;
   logic signed [17:0] il_sum, vc_sum;
   logic [15:0]        il_next, vc_next;
   logic               il_clamp, vc_clamp;

   assign il_o = il_q[15:8];
   assign vc_o = vc_q[15:8];
   assign tick = enable_i && (cnt == CNT_LAST);

   // Two-flop synchroniser for the pad-domain gate command
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         gate_m <= 1'b0;
         gate_s <= 1'b0;
      end else begin
         gate_m <= gate_i;
         gate_s <= gate_m;
      end
   end

   // Step divider: counts only while enabled, wraps after the tick cycle
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         cnt <= '0;
      end else if (enable_i) begin
         if (cnt == CNT_LAST) cnt <= '0;
         else                 cnt <= cnt + 1'b1;
      end
   end

   // Plant equations and clamping; all operands are the current register values
   always_comb begin
      il_w   = signed'({10'd0, il_o});
      vc_w   = signed'({10'd0, vc_o});
      vg_w   = signed'({10'd0, vg_o});
      i_load = signed'({10'd0, vc_o} >> R_SHIFT);

      v_l = gate_s ? vg_w : (vg_w - vc_w);
      i_c = gate_s ? -i_load : (il_w - i_load);

      il_sum = signed'({2'b00, il_q}) + (v_l <<< (8 - L_SHIFT));
      vc_sum = signed'({2'b00, vc_q}) + (i_c <<< (8 - C_SHIFT));

      il_next  = il_sum[15:0];
      il_clamp = 1'b0;
      if (il_sum < 0) begin
         il_next  = 16'h0000;
         il_clamp = 1'b1;
      end else if (il_sum > 18'sd65535) begin
         il_next  = 16'hFFFF;
         il_clamp = 1'b1;
      end

      vc_next  = vc_sum[15:0];
      vc_clamp = 1'b0;
      if (vc_sum < 0) begin
         vc_next  = 16'h0000;
         vc_clamp = 1'b1;
      end else if (vc_sum > 18'sd65535) begin
         vc_next  = 16'hFFFF;
         vc_clamp = 1'b1;
      end
   end

   // State update on tick, sticky saturation flag, source-voltage register
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         il_q    <= 16'h0000;
         vc_q    <= 16'h0000;
         vg_o    <= VG_DEFAULT;
         valid_o <= 1'b0;
         sat_o   <= 1'b0;
      end else begin
         valid_o <= tick;
         if (tick) begin
            il_q <= il_next;
            vc_q <= vc_next;
            if (il_clamp || vc_clamp) sat_o <= 1'b1;
         end
         if (vg_load_i) vg_o <= vg_set_i;
      end
   end

endmodule

// File: tb/tb_boost_plant_emulator.sv
// Directed bench for boost_plant_emulator with hand-computed expectations.
module tb_boost_plant_emulator;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic       enable_i;
   logic       gate_i;
   logic       vg_load_i;
   logic [7:0] vg_set_i;
   logic [7:0] il_o, vc_o, vg_o;
   logic       valid_o, sat_o;

   int vectors = 0;
   int errors  = 0;

   boost_plant_emulator dut (
      .wb_clk_i  (wb_clk_i),
      .wb_rst_i  (wb_rst_i),
      .enable_i  (enable_i),
      .gate_i    (gate_i),
      .vg_load_i (vg_load_i),
      .vg_set_i  (vg_set_i),
      .il_o      (il_o),
      .vc_o      (vc_o),
      .vg_o      (vg_o),
      .valid_o   (valid_o),
      .sat_o     (sat_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         cyc();
         n++;
      end while (!valid_o && n < 300);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int total;
      logic saw;
      logic [7:0] prev;
      logic reached;

      wb_rst_i  = 1'b1;
      enable_i  = 1'b0;
      gate_i    = 1'b0;
      vg_load_i = 1'b0;
      vg_set_i  = 8'd0;

      // T1: reset state
      repeat (3) cyc();
      chk("t1_il", il_o, 0);
      chk("t1_vc", vc_o, 0);
      chk("t1_vg", vg_o, 12);
      chk("t1_valid", valid_o, 0);
      chk("t1_sat", sat_o, 0);

      // T2: charge, four steps with switch closed
      wb_rst_i = 1'b0;
      enable_i = 1'b1;
      gate_i   = 1'b1;
      wait_valid(n);
      chk("t5_first_tick", n, 100);
      for (int i = 0; i < 3; i++) begin
         wait_valid(n);
         chk("t5_period", n, 100);
      end
      chk("t2_il_q", dut.il_q, 768);
      chk("t2_il", il_o, 3);
      chk("t2_vc", vc_o, 0);
      chk("t2_sat", sat_o, 0);

      // T3: one boost step
      gate_i = 1'b0;
      wait_valid(n);
      chk("t3_period", n, 100);
      chk("t3_il_q", dut.il_q, 960);
      chk("t3_vc_q", dut.vc_q, 24);
      chk("t3_il", il_o, 3);
      chk("t3_vc", vc_o, 0);
      cyc();
      chk("t3_pulse_once", valid_o, 0);

      // T4 setup plus T5 freeze inside the first saturating step
      gate_i    = 1'b1;
      vg_set_i  = 8'd255;
      vg_load_i = 1'b1;
      cyc();
      vg_load_i = 1'b0;
      chk("t4_vg_loaded", vg_o, 255);
      repeat (48) cyc();
      enable_i = 1'b0;
      saw = 1'b0;
      for (int i = 0; i < 37; i++) begin
         cyc();
         if (valid_o) saw = 1'b1;
      end
      chk("t5_frozen_valid", saw, 0);
      chk("t5_frozen_il_q", dut.il_q, 960);
      chk("t5_frozen_vc_q", dut.vc_q, 24);
      enable_i = 1'b1;
      wait_valid(n);
      total = 2 + 48 + 37 + n;
      chk("t5_frozen_period", total, 137);
      chk("t4_step1_il_q", dut.il_q, 5040);
      chk("t4_step1_il", il_o, 19);

      // T4: saturate inductor current
      repeat (14) wait_valid(n);
      chk("t4_step15_il", il_o, 242);
      chk("t4_step15_sat", sat_o, 0);
      wait_valid(n);
      chk("t4_step16_il", il_o, 255);
      chk("t4_step16_il_q", dut.il_q, 16'hFFFF);
      chk("t4_step16_sat", sat_o, 1);
      for (int i = 0; i < 64; i++) begin
         wait_valid(n);
         chk("t4_hold", il_o, 255);
      end
      chk("t4_vc", vc_o, 0);

      // T4: open switch, charge cap, then drop vg below vc and drain iL to zero
      gate_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         wait_valid(n);
         chk("t4_boost_hold", il_o, 255);
      end
      prev      = il_o;
      vg_set_i  = 8'd10;
      vg_load_i = 1'b1;
      cyc();
      vg_load_i = 1'b0;
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         wait_valid(n);
         chk("t4_drain_no_rise", (il_o <= prev), 1);
         prev = il_o;
         if (il_o == 8'd0) reached = 1'b1;
      end
      chk("t4_drain_reached_zero", reached, 1);
      wait_valid(n);
      chk("t4_drain_stays_zero", il_o, 0);
      chk("t4_sat_sticky", sat_o, 1);

      // T6: reset at count=50
      wait_valid(n);
      repeat (50) cyc();
      wb_rst_i = 1'b1;
      gate_i   = 1'b1;
      cyc();
      chk("t6_rst_il", il_o, 0);
      chk("t6_rst_vc", vc_o, 0);
      chk("t6_rst_vg", vg_o, 12);
      chk("t6_rst_valid", valid_o, 0);
      chk("t6_rst_sat", sat_o, 0);
      wb_rst_i = 1'b0;
      wait_valid(n);
      chk("t6_first_tick", n, 100);
      chk("t6_step1_il_q", dut.il_q, 192);

      // T6: vg load coincident with tick uses the old vg
      repeat (99) cyc();
      vg_set_i  = 8'd100;
      vg_load_i = 1'b1;
      cyc();
      vg_load_i = 1'b0;
      chk("t6_tick_valid", valid_o, 1);
      chk("t6_old_vg_il_q", dut.il_q, 384);
      chk("t6_old_vg_il", il_o, 1);
      chk("t6_vg_after", vg_o, 100);
      wait_valid(n);
      chk("t6_period", n, 100);
      chk("t6_new_vg_il_q", dut.il_q, 1984);
      chk("t6_new_vg_il", il_o, 7);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
